mux16_scan_ctrl: RTL and testbench

- Sequential controller that sits directly upstream of the 16:1 bit mux.
- Drives the mux select lines and samples the mux output back in.
- Either scans all 16 channels into a 16-bit word or reads one addressed channel.
- Inserts a programmable settle time per channel and reports completion with a busy/valid handshake.

---
 rtl/mux16_scan_ctrl_if.sv | 21 ++
 rtl/mux16_scan_ctrl.sv | 100 ++++++++++
 tb/tb_mux16_scan_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mux16_scan_ctrl_if.sv
// Bus between the scan controller and its client: request/handshake, mux select and sampled bit.
interface mux16_scan_ctrl_if;
    logic        start;
    logic        single;
    logic [3:0]  ch;
    logic        mux_out;
    logic [3:0]  sel;
    logic        busy;
    logic [15:0] data;
    logic        valid;

    modport master (
        output start, single, ch, mux_out,
        input  sel, busy, data, valid
    );

    modport slave (
        input  start, single, ch, mux_out,
        output sel, busy, data, valid
    );
endinterface

// File: rtl/mux16_scan_ctrl.sv
// Drives the select lines of a 16:1 bit mux, waits SETTLE cycles per channel and samples the mux
// output back, either for all 16 channels or one addressed channel.
module mux16_scan_ctrl #(
    parameter int unsigned SETTLE = 2
) (
    input logic               clk,
    input logic               rst_n,
    mux16_scan_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StSettle, StSample} state_e;

    // SETTLE state lasts SETTLE-1 cycles; SAMPLE supplies the final cycle of each channel.
    localparam bit         SkipSettle = (SETTLE == 1);
    localparam logic [3:0] SettleLast = 4'(SETTLE - 2);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  sel_q, sel_d;
    logic        single_q, single_d;
    logic [15:0] shadow_q, shadow_d;
    logic [15:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic [15:0] merged;
    logic        last_ch;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        single_d = single_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        valid_d  = 1'b0;

        merged          = shadow_q;
        merged[sel_q]   = bus.mux_out;
        last_ch         = single_q || (sel_q == 4'd15);

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    single_d = bus.single;
                    sel_d    = bus.single ? bus.ch : 4'd0;
                    // Untouched bits of a single read keep their previous value.
                    shadow_d = data_q;
                    cnt_d    = 4'd0;
                    state_d  = SkipSettle ? StSample : StSettle;
                end
            end
            StSettle: begin
                if (cnt_q == SettleLast) begin
                    cnt_d   = 4'd0;
                    state_d = StSample;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StSample: begin
                if (last_ch) begin
                    data_d  = merged;
                    valid_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    shadow_d = merged;
                    sel_d    = sel_q + 4'd1;
                    cnt_d    = 4'd0;
                    state_d  = SkipSettle ? StSample : StSettle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            sel_q    <= 4'd0;
            single_q <= 1'b0;
            shadow_q <= 16'h0000;
            data_q   <= 16'h0000;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            single_q <= single_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.sel   = sel_q;
    assign bus.busy  = (state_q != StIdle);
    assign bus.data  = data_q;
    assign bus.valid = valid_q;

endmodule

// File: tb/tb_mux16_scan_ctrl.sv
// Directed bench for mux16_scan_ctrl (SETTLE=2) with a behavioural 16:1 mux on the select lines.
module tb_mux16_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in_w = 16'h0000;
    int          total = 0;
    int          bad = 0;

    mux16_scan_ctrl_if bus_if ();

    mux16_scan_ctrl #(.SETTLE(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    assign bus_if.mux_out = in_w[bus_if.sel];

    always #5 clk = ~clk;

    typedef struct {
        logic        single;
        logic [3:0]  ch;
        logic [15:0] in_word;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp_v, $time);
        end
    endtask

    // Start one operation, then check busy/sel every cycle and the completion cycle.
    task automatic run_op(input logic sgl, input logic [3:0] c, input logic [15:0] iw,
                          input logic [15:0] exp_d);
        int lat;
        lat = sgl ? 2 : 32;
        @(negedge clk);
        in_w = iw;
        bus_if.single = sgl;
        bus_if.ch = c;
        bus_if.start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= lat; n++) begin
            @(negedge clk);
            if (n == 1) bus_if.start = 1'b0;
            chk("op_busy", 32'(bus_if.busy), 32'd1);
            chk("op_valid_early", 32'(bus_if.valid), 32'd0);
            chk("op_sel", 32'(bus_if.sel), sgl ? 32'(c) : 32'((n - 1) / 2));
        end
        @(negedge clk);
        chk("op_valid", 32'(bus_if.valid), 32'd1);
        chk("op_busy_done", 32'(bus_if.busy), 32'd0);
        chk("op_data", 32'(bus_if.data), 32'(exp_d));
        chk("op_sel_hold", 32'(bus_if.sel), sgl ? 32'(c) : 32'd15);
        @(negedge clk);
        chk("op_valid_pulse", 32'(bus_if.valid), 32'd0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 4'd0,  16'hA5C3, 16'hA5C3};
        vecs[1] = '{1'b1, 4'd9,  16'hA7C3, 16'hA7C3};
        vecs[2] = '{1'b1, 4'd0,  16'h0000, 16'hA7C2};
        vecs[3] = '{1'b0, 4'd0,  16'h0F0F, 16'h0F0F};
        vecs[4] = '{1'b1, 4'd15, 16'hFFFF, 16'h8F0F};
        vecs[5] = '{1'b0, 4'd0,  16'h1234, 16'h1234};

        // Reset hold with start asserted.
        bus_if.start = 1'b1;
        bus_if.single = 1'b0;
        bus_if.ch = 4'd0;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_sel", 32'(bus_if.sel), 32'd0);
            chk("rst_busy", 32'(bus_if.busy), 32'd0);
            chk("rst_valid", 32'(bus_if.valid), 32'd0);
            chk("rst_data", 32'(bus_if.data), 32'd0);
        end
        bus_if.start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 32'(bus_if.busy), 32'd0);

        for (int v = 0; v < 6; v++)
            run_op(vecs[v].single, vecs[v].ch, vecs[v].in_word, vecs[v].exp_data);

        // Back-to-back full scans with start held high.
        @(negedge clk);
        in_w = 16'h0F0F;
        bus_if.single = 1'b0;
        bus_if.start = 1'b1;
        @(posedge clk);
        for (int s = 0; s < 3; s++) begin
            for (int n = 1; n <= 33; n++) begin
                @(negedge clk);
                if (n <= 32) begin
                    chk("b2b_busy", 32'(bus_if.busy), 32'd1);
                    chk("b2b_valid_early", 32'(bus_if.valid), 32'd0);
                end else begin
                    chk("b2b_valid", 32'(bus_if.valid), 32'd1);
                    chk("b2b_busy_done", 32'(bus_if.busy), 32'd0);
                    chk("b2b_data", 32'(bus_if.data), (s % 2 == 0) ? 32'h0F0F : 32'hF0F0);
                    in_w = ~in_w;
                    if (s == 2) bus_if.start = 1'b0;
                end
            end
        end
        @(negedge clk);
        chk("b2b_stop_busy", 32'(bus_if.busy), 32'd0);
        chk("b2b_stop_valid", 32'(bus_if.valid), 32'd0);

        // Start/single/ch changes while busy must be ignored.
        in_w = 16'h3C5A;
        bus_if.single = 1'b0;
        bus_if.start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 33; n++) begin
            @(negedge clk);
            if (n <= 32) begin
                chk("ign_busy", 32'(bus_if.busy), 32'd1);
                chk("ign_sel", 32'(bus_if.sel), 32'((n - 1) / 2));
            end else begin
                chk("ign_valid", 32'(bus_if.valid), 32'd1);
                chk("ign_data", 32'(bus_if.data), 32'h3C5A);
            end
            if (n == 1) bus_if.start = 1'b0;
            if (n == 9) begin
                bus_if.start = 1'b1;
                bus_if.single = 1'b1;
                bus_if.ch = 4'd3;
            end
            if (n == 11) begin
                bus_if.start = 1'b0;
                bus_if.single = 1'b0;
            end
        end
        @(negedge clk);
        chk("ign_idle", 32'(bus_if.busy), 32'd0);

        // Reset in the middle of a scan at sel=7.
        in_w = 16'hFFFF;
        bus_if.start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 15; n++) begin
            @(negedge clk);
            if (n == 1) bus_if.start = 1'b0;
        end
        chk("mid_sel7", 32'(bus_if.sel), 32'd7);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_sel", 32'(bus_if.sel), 32'd0);
        chk("mid_rst_busy", 32'(bus_if.busy), 32'd0);
        chk("mid_rst_data", 32'(bus_if.data), 32'd0);
        chk("mid_rst_valid", 32'(bus_if.valid), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("mid_no_valid", 32'(bus_if.valid), 32'd0);
            chk("mid_no_busy", 32'(bus_if.busy), 32'd0);
        end
        run_op(1'b0, 4'd0, 16'h6B9D, 16'h6B9D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
